mult_div_unit: RTL and testbench

Iterative multiply/divide unit for the single-cycle MIPS core's execute stage. It executes MULT, MULTU, DIV and DIVU over multiple cycles and drives the HI/LO register write port, `regHiLoWrite` plus the two-word result. `busy` lets the control unit stall MFHI/MFLO and any further multiply/divide until the result has been written.

---
 rtl/mult_div_unit.sv | 167 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative 32-bit MULT/MULTU/DIV/DIVU unit driving the HI/LO write
//            port. Optional multiply early-out: define MULTDIV_EARLY_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [31:0]      rs,
    input  logic [31:0]      rt,
    output logic             busy,
    output logic             done,
    output logic             regHiLoWrite,
    output logic [1:0][31:0] outputHiLo
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_SIGN  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        div_q, div_d;
    logic [63:0] acc_q, acc_d;      // product, or {remainder, quotient}
    logic [63:0] opa_q, opa_d;      // shifting multiplicand, or divisor in [31:0]
    logic [31:0] opb_q, opb_d;      // shifting multiplier, or raw dividend
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic        dbz_q, dbz_d;
    logic [63:0] res_q, res_d;      // {HI, LO}

    logic        w_signed;
    logic [31:0] w_abs_rs;
    logic [31:0] w_abs_rt;
    logic [32:0] w_rem_sh;
    logic        w_ge;
    logic [31:0] w_diff;

    assign w_signed = ~op[0];
    assign w_abs_rs = (w_signed && rs[31]) ? (32'd0 - rs) : rs;
    assign w_abs_rt = (w_signed && rt[31]) ? (32'd0 - rt) : rt;

    // Remainder after the left shift can be 33 bits wide before the trial subtract.
    assign w_rem_sh = acc_q[63:31];
    assign w_ge     = (w_rem_sh >= {1'b0, opa_q[31:0]});
    assign w_diff   = w_rem_sh[31:0] - opa_q[31:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN: begin
                if (cnt_q == 5'd0) begin
                    state_d = S_SIGN;
                end
`ifdef MULTDIV_EARLY_OUT_EN
                else if (!div_q && (opb_q[31:1] == 31'd0)) begin
                    state_d = S_SIGN;
                end
`endif
            end
            S_SIGN:  state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != S_IDLE);
        regHiLoWrite = (state_q == S_WRITE);
        done         = (state_q == S_WRITE);
        outputHiLo[0] = res_q[63:32];
        outputHiLo[1] = res_q[31:0];
    end

    always_comb begin
        div_d    = div_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dbz_d    = dbz_q;
        res_d    = res_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    div_d    = op[1];
                    neg_lo_d = w_signed & (rs[31] ^ rt[31]);
                    neg_hi_d = w_signed & op[1] & rs[31];
                    dbz_d    = op[1] & (rt == 32'd0);
                    cnt_d    = 5'd31;
                    if (op[1]) begin
                        acc_d = {32'd0, w_abs_rs};
                        opa_d = {32'd0, w_abs_rt};
                        opb_d = rs;
                    end else begin
                        acc_d = 64'd0;
                        opa_d = {32'd0, w_abs_rs};
                        opb_d = w_abs_rt;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 5'd1;
                if (div_q) begin
                    acc_d = {(w_ge ? w_diff : w_rem_sh[31:0]), acc_q[30:0], w_ge};
                end else begin
                    acc_d = acc_q + (opb_q[0] ? opa_q : 64'd0);
                    opa_d = {opa_q[62:0], 1'b0};
                    opb_d = {1'b0, opb_q[31:1]};
                end
            end
            S_SIGN: begin
                if (dbz_q) begin
                    res_d = {opb_q, 32'hFFFF_FFFF};
                end else if (div_q) begin
                    res_d[63:32] = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
                    res_d[31:0]  = neg_lo_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
                end else begin
                    res_d = neg_lo_q ? (64'd0 - acc_q) : acc_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q    <= 1'b0;
            acc_q    <= 64'd0;
            opa_q    <= 64'd0;
            opb_q    <= 32'd0;
            cnt_q    <= 5'd0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dbz_q    <= 1'b0;
            res_q    <= 64'd0;
        end else begin
            div_q    <= div_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dbz_q    <= dbz_d;
            res_q    <= res_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Directed self-checking bench for mult_div_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

`ifdef MULTDIV_EARLY_OUT_EN
    localparam bit C_EARLY = 1'b1;
`else
    localparam bit C_EARLY = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [31:0]      rs;
    logic [31:0]      rt;
    logic             busy;
    logic             done;
    logic             regHiLoWrite;
    logic [1:0][31:0] outputHiLo;

    int n_checks = 0;
    int n_pass   = 0;

    mult_div_unit u_dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .rs           (rs),
        .rt           (rt),
        .busy         (busy),
        .done         (done),
        .regHiLoWrite (regHiLoWrite),
        .outputHiLo   (outputHiLo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Issue one op, scramble the operand inputs after acceptance, then check
    // latency, busy duration and the written HI/LO pair.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int elat, input string tag);
        int cyc;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b;
        @(posedge clk); #1;
        start = 1'b0; rs = $urandom; rt = $urandom; op = 2'($urandom_range(3, 0));
        cyc = 0;
        busy_cnt = 0;
        while (!regHiLoWrite && cyc < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            cyc++;
        end
        if (busy) busy_cnt++;
        check({tag, " no_timeout"}, 64'(cyc < 100), 64'd1);
        check({tag, " latency"}, 64'(cyc + 1), 64'(elat));
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(elat));
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " hi"}, 64'(outputHiLo[0]), 64'(ehi));
        check({tag, " lo"}, 64'(outputHiLo[1]), 64'(elo));
        @(posedge clk); #1;
        check({tag, " write_drop"}, 64'(regHiLoWrite), 64'd0);
        check({tag, " busy_drop"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int writes;
        logic [1:0][31:0] got;
        reset = 1'b0; start = 1'b0; op = 2'b00; rs = 32'd0; rt = 32'd0;
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst write", 64'(regHiLoWrite), 64'd0);
        check("rst hilo", 64'(outputHiLo), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, C_EARLY ? 4 : 34, "mult_7x-3");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34, "multu_max");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, "div_-7/2");
        run_op(2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 34, "divu_by0");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 34, "div_by0");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34, "div_ovf");
        run_op(2'b01, 32'd5, 32'd1, 32'd0, 32'd5, C_EARLY ? 3 : 34, "multu_5x1");
        run_op(2'b00, 32'd5, 32'd0, 32'd0, 32'd0, C_EARLY ? 3 : 34, "mult_5x0");
        run_op(2'b00, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'd0, 32'd64, C_EARLY ? 6 : 34, "mult_-8x-8");
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 34, "divu_100/7");

        // A second start during RUN must be dropped, not queued.
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs = 32'd3; rt = 32'h8000_0000;
        @(posedge clk); #1;
        start = 1'b0;
        writes = 0;
        got = '0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 10) begin
                start = 1'b1; op = 2'b11; rs = 32'd9; rt = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (regHiLoWrite) begin
                writes++;
                got = outputHiLo;
            end
        end
        check("ignore writes", 64'(writes), 64'd1);
        check("ignore hi", 64'(got[0]), 64'd1);
        check("ignore lo", 64'(got[1]), 64'h8000_0000);
        check("ignore idle", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; op = 2'b11; rs = 32'd100; rt = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst write", 64'(regHiLoWrite), 64'd0);
        check("midrst hilo", 64'(outputHiLo), 64'd0);
        writes = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (regHiLoWrite) writes++;
        end
        check("midrst no_write", 64'(writes), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("postrst idle", 64'(busy), 64'd0);
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 34, "postrst_divu");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
